// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the multiplier writeback buffer.
package cv32e40x_pkg;

  localparam int MUL_WB_DEPTH   = 2;
  localparam int MUL_WB_RADDR_W = 5;

  typedef struct packed {
    logic [31:0]               result;
    logic [MUL_WB_RADDR_W-1:0] rd;
    logic                      we;
  } mul_wb_entry_t;

endpackage

// File: rtl/cv32e40x_mul_wb_hazard.sv
// Combinational RAW check of buffered destinations against ID source registers.
module cv32e40x_mul_wb_hazard #(
  parameter int DEPTH   = 2,
  parameter int RADDR_W = 5
) (
  input  logic [DEPTH-1:0]              valid,
  input  logic [DEPTH-1:0][RADDR_W-1:0] rd,
  input  logic [DEPTH-1:0]              we,
  input  logic [RADDR_W-1:0]            rs1_i,
  input  logic [RADDR_W-1:0]            rs2_i,
  output logic                          hazard_o
);

  logic [DEPTH-1:0] hit;

  // x0 is hardwired to zero, so a pending write to it can never be a dependency
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign hit[g] = valid[g] && we[g] && (rd[g] != '0) &&
                    ((rd[g] == rs1_i) || (rd[g] == rs2_i));
  end

  assign hazard_o = |hit;

endmodule

// File: rtl/cv32e40x_mul_wb_buffer.sv
// Result FIFO between multiplier and writeback with pending-destination hazard flag.
module cv32e40x_mul_wb_buffer
  import cv32e40x_pkg::*;
#(
  parameter int DEPTH   = MUL_WB_DEPTH,
  parameter int RADDR_W = MUL_WB_RADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       mul_valid_i,
  output logic                       mul_ready_o,
  input  logic [31:0]                mul_result_i,
  input  logic [RADDR_W-1:0]         mul_rd_i,
  input  logic                       mul_we_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [31:0]                wb_result_o,
  output logic [RADDR_W-1:0]         wb_rd_o,
  output logic                       wb_we_o,
  input  logic [RADDR_W-1:0]         rs1_i,
  input  logic [RADDR_W-1:0]         rs2_i,
  output logic                       hazard_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  mul_wb_entry_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]          valid_q;
  logic [PW-1:0]             wptr_q, rptr_q;
  logic [CW-1:0]             count_q;

  logic          push, pop;
  mul_wb_entry_t head;

  assign mul_ready_o = (count_q < CW'(DEPTH));
  assign push        = mul_valid_i && mul_ready_o;
  assign pop         = wb_valid_o && wb_ready_i;
  assign count_o     = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q]   <= '{result: mul_result_i, rd: mul_rd_i, we: mul_we_i};
        valid_q[wptr_q] <= 1'b1;
        wptr_q          <= wptr_q + 1'b1;
      end
      // push and pop never target the same slot: empty blocks pop, full blocks push
      if (pop) begin
        valid_q[rptr_q] <= 1'b0;
        rptr_q          <= rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head fields are zeroed when empty so stale slot data never leaks out
  assign wb_valid_o  = valid_q[rptr_q];
  assign head        = wb_valid_o ? mem_q[rptr_q] : '0;
  assign wb_result_o = head.result;
  assign wb_rd_o     = head.rd;
  assign wb_we_o     = head.we;

  logic [DEPTH-1:0][RADDR_W-1:0] ent_rd;
  logic [DEPTH-1:0]              ent_we;

  for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
    assign ent_rd[g] = mem_q[g].rd;
    assign ent_we[g] = mem_q[g].we;
  end

  cv32e40x_mul_wb_hazard #(
    .DEPTH   (DEPTH),
    .RADDR_W (RADDR_W)
  ) u_hazard (
    .valid    (valid_q),
    .rd       (ent_rd),
    .we       (ent_we),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .hazard_o (hazard_o)
  );

endmodule

// File: tb/tb_cv32e40x_mul_wb_buffer.sv
// Directed bench for cv32e40x_mul_wb_buffer (DEPTH=2).
module tb_cv32e40x_mul_wb_buffer;

  logic        clk = 1'b0;
  logic        rst_n, flush_i;
  logic        mul_valid_i, mul_ready_o, mul_we_i;
  logic [31:0] mul_result_i;
  logic [4:0]  mul_rd_i;
  logic        wb_valid_o, wb_ready_i, wb_we_o;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_rd_o, rs1_i, rs2_i;
  logic        hazard_o;
  logic [1:0]  count_o;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  cv32e40x_mul_wb_buffer #(.DEPTH(2), .RADDR_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .mul_valid_i  (mul_valid_i),
    .mul_ready_o  (mul_ready_o),
    .mul_result_i (mul_result_i),
    .mul_rd_i     (mul_rd_i),
    .mul_we_i     (mul_we_i),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .wb_result_o  (wb_result_o),
    .wb_rd_o      (wb_rd_o),
    .wb_we_o      (wb_we_o),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .hazard_o     (hazard_o),
    .count_o      (count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
    chk("occupancy_le_depth", {31'd0, (count_o <= 2'd2)}, 32'd1);
  endtask

  task automatic offer(input logic [31:0] res, input logic [4:0] rd, input logic we);
    mul_valid_i  = 1'b1;
    mul_result_i = res;
    mul_rd_i     = rd;
    mul_we_i     = we;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; mul_valid_i = 1'b0; mul_result_i = '0;
    mul_rd_i = '0; mul_we_i = 1'b0; wb_ready_i = 1'b0; rs1_i = '0; rs2_i = '0;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_mul_ready", mul_ready_o, 1);
    chk("rst_wb_valid",  wb_valid_o,  0);
    chk("rst_count",     count_o,     0);
    chk("rst_hazard",    hazard_o,    0);
    chk("rst_wb_result", wb_result_o, 0);
    chk("rst_wb_rd",     wb_rd_o,     0);
    chk("rst_wb_we",     wb_we_o,     0);

    // single pass
    wb_ready_i = 1'b1;
    offer(32'hDEADBEEF, 5'd5, 1'b1);
    chk("sp_no_bypass", wb_valid_o, 0);
    step();
    mul_valid_i = 1'b0; rs1_i = 5'd5;
    #1;
    chk("sp_valid",  wb_valid_o,  1);
    chk("sp_result", wb_result_o, 32'hDEADBEEF);
    chk("sp_rd",     wb_rd_o,     5);
    chk("sp_we",     wb_we_o,     1);
    chk("sp_count",  count_o,     1);
    chk("sp_hazard_popping", hazard_o, 1);
    step();
    rs1_i = 5'd0;
    #1;
    chk("sp_count_after", count_o,    0);
    chk("sp_valid_after", wb_valid_o, 0);
    chk("sp_result_zero", wb_result_o, 0);
    chk("sp_hazard_after", hazard_o,  0);

    // backpressure / full
    wb_ready_i = 1'b0;
    offer(32'h11, 5'd1, 1'b1); step();
    offer(32'h22, 5'd2, 1'b1); step();
    chk("bp_count_full", count_o,     2);
    chk("bp_not_ready",  mul_ready_o, 0);
    offer(32'h33, 5'd3, 1'b1); step();
    mul_valid_i = 1'b0;
    #1;
    chk("bp_third_rejected", count_o, 2);
    chk("bp_head_hold",  wb_result_o, 32'h11);
    chk("bp_head_rd",    wb_rd_o,     1);
    wb_ready_i = 1'b1;
    step();
    chk("bp_second",     wb_result_o, 32'h22);
    chk("bp_ready_again", mul_ready_o, 1);
    chk("bp_count_1",    count_o,     1);
    step();
    chk("bp_drained",    wb_valid_o,  0);
    chk("bp_count_0",    count_o,     0);

    // streaming with simultaneous push/pop, pointers wrap
    offer(32'h1, 5'd10, 1'b1); step();
    for (int i = 2; i <= 6; i++) begin
      offer(i, 5'd10, 1'b1);
      #1;
      chk("st_head",  wb_result_o, i - 1);
      chk("st_count", count_o,     1);
      step();
    end
    mul_valid_i = 1'b0;
    #1;
    chk("st_last",  wb_result_o, 32'h6);
    chk("st_count_last", count_o, 1);
    step();
    chk("st_empty", count_o, 0);

    // hazard
    wb_ready_i = 1'b0;
    offer(32'h70, 5'd7, 1'b1); step();
    offer(32'h00, 5'd0, 1'b1); step();
    mul_valid_i = 1'b0;
    rs1_i = 5'd7; rs2_i = 5'd0; #1;
    chk("hz_rs1_7", hazard_o, 1);
    rs1_i = 5'd3; rs2_i = 5'd7; #1;
    chk("hz_rs2_7", hazard_o, 1);
    rs1_i = 5'd0; rs2_i = 5'd0; #1;
    chk("hz_rd0", hazard_o, 0);
    wb_ready_i = 1'b1;
    step(); step();
    chk("hz_drained", count_o, 0);
    wb_ready_i = 1'b0;
    offer(32'h90, 5'd9, 1'b0); step();
    mul_valid_i = 1'b0;
    rs2_i = 5'd9; #1;
    chk("hz_we0", hazard_o, 0);
    chk("hz_we0_head_we", wb_we_o, 0);

    // flush while full with a push offered
    offer(32'hAA, 5'd4, 1'b1); step();
    chk("fl_full", count_o, 2);
    offer(32'hBB, 5'd6, 1'b1);
    flush_i = 1'b1; wb_ready_i = 1'b1;
    step();
    flush_i = 1'b0; mul_valid_i = 1'b0; rs2_i = 5'd0;
    #1;
    chk("fl_count",  count_o,     0);
    chk("fl_valid",  wb_valid_o,  0);
    chk("fl_ready",  mul_ready_o, 1);
    step();
    chk("fl_bb_absent", wb_valid_o, 0);

    // flush with an accepted push in the same cycle
    wb_ready_i = 1'b0;
    offer(32'hCC, 5'd8, 1'b1); step();
    offer(32'hDD, 5'd8, 1'b1);
    flush_i = 1'b1;
    #1;
    chk("fl2_ready_ungated", mul_ready_o, 1);
    step();
    flush_i = 1'b0; mul_valid_i = 1'b0;
    #1;
    chk("fl2_count", count_o,    0);
    chk("fl2_valid", wb_valid_o, 0);
    step();
    chk("fl2_dd_absent", wb_valid_o, 0);

    // reset mid-operation
    offer(32'hEE, 5'd2, 1'b1); step();
    mul_valid_i = 1'b0; wb_ready_i = 1'b1; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("mr_count",  count_o,     0);
    chk("mr_valid",  wb_valid_o,  0);
    chk("mr_result", wb_result_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
